// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register and instruction-fetch sequencer for the RV32I core.
//   Fetches one instruction at a time over a req/ack handshake, holds it for
//   decode while Stall is high, then retires it. On retirement the next PC is
//   either PC+4 or the branch target PC+ImmExt, as chosen by PCSrc.
//
//   Optional feature: define FETCH_TIMEOUT_EN to abandon a fetch that is not
//   acknowledged within TIMEOUT_CYCLES request cycles. The fetch unit then
//   raises FetchTimeout and halts. Without the macro, a request waits forever
//   and FetchTimeout is constant 0.
//
// Ports
//   clk, rst              core clock; synchronous active-high reset
//   PCSrc, ImmExt         branch select / byte offset, used only at retirement
//   Stall                 hold the current instruction in EXEC
//   IMemReq, IMemAddr     fetch request and address (address = PC)
//   IMemAck, IMemRData    memory acknowledge and instruction word
//   Instr, InstrValid     registered instruction presented to decode
//   PC, PCPlus4           current PC and its link value
//   MisalignErr           sticky: a retired target was not word aligned
//   FetchTimeout          sticky: a fetch timed out (FETCH_TIMEOUT_EN only)
//
// state  | meaning
// IDLE   | after reset; start a fetch on the next edge
// REQ    | request outstanding at PC, waiting for IMemAck
// EXEC   | instruction valid for decode; retire when Stall is low
// HALT   | misaligned target or fetch timeout; left only through rst

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignErr,
  output logic        FetchTimeout
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_misalign;

  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_retire;
  logic        w_ack;
  logic        w_timeout;

  // Target add wraps modulo 2^32 by construction.
  assign w_target   = PCSrc ? (r_pc + ImmExt) : (r_pc + 32'd4);
  assign w_misalign = |w_target[1:0];
  assign w_retire   = (r_state == S_EXEC) && !Stall;
  assign w_ack      = (r_state == S_REQ) && IMemAck;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] r_tmo_cnt;
  logic       r_fetch_tmo;

  // The last unacknowledged REQ cycle is the one where the count already
  // shows TIMEOUT_CYCLES-1 earlier misses.
  assign w_timeout = (r_state == S_REQ) && !IMemAck && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt   <= '0;
      r_fetch_tmo <= 1'b0;
    end else begin
      // Held at zero outside REQ, so every REQ entry starts from zero.
      if (r_state != S_REQ)
        r_tmo_cnt <= '0;
      else if (!IMemAck)
        r_tmo_cnt <= r_tmo_cnt + 5'd1;
      if (w_timeout)
        r_fetch_tmo <= 1'b1;
    end
  end

  assign FetchTimeout = r_fetch_tmo;
`else
  assign w_timeout    = 1'b0;
  // Folds to constant 0; keeps the parameter referenced in this build.
  assign FetchTimeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    IMemReq     = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        IMemReq = 1'b1;
        if (IMemAck)
          w_state_nxt = S_EXEC;
        else if (w_timeout)
          w_state_nxt = S_HALT;
      end
      S_EXEC: begin
        if (!Stall)
          w_state_nxt = w_misalign ? S_HALT : S_REQ;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_ack) begin
        r_instr <= IMemRData;
        r_valid <= 1'b1;
      end
      if (w_retire) begin
        r_valid <= 1'b0;
        // A misaligned target leaves PC pointing at the offending instruction.
        if (w_misalign)
          r_misalign <= 1'b1;
        else
          r_pc <= w_target;
      end
    end
  end

  assign IMemAddr    = r_pc;
  assign PC          = r_pc;
  assign PCPlus4     = r_pc + 32'd4;
  assign Instr       = r_instr;
  assign InstrValid  = r_valid;
  assign MisalignErr = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TMO      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        Stall;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignErr;
  logic        FetchTimeout;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_pct   = 100;
  int stall_pct = 0;
  int br_pct    = 0;
  int mis_pct   = 0;
  bit chk_en    = 1'b0;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .ImmExt(ImmExt), .Stall(Stall),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRData(IMemRData),
    .Instr(Instr), .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
    .MisalignErr(MisalignErr), .FetchTimeout(FetchTimeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch unit is doing, tracked per clock edge.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_HOLD = 2, PH_DEAD = 3;
  int          m_ph;
  int          m_wait;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_mis;
  bit          m_to;

  always @(posedge clk) begin
    logic [31:0] tgt;
    if (rst) begin
      m_ph = PH_IDLE; m_wait = 0; m_pc = RESET_PC; m_instr = 32'h0000_0013;
      m_valid = 0; m_mis = 0; m_to = 0;
    end else begin
      case (m_ph)
        PH_IDLE: begin m_ph = PH_FETCH; m_wait = 0; end
        PH_FETCH: begin
          if (IMemAck) begin
            m_instr = IMemRData; m_valid = 1; m_ph = PH_HOLD;
          end else begin
            m_wait++;
`ifdef FETCH_TIMEOUT_EN
            if (m_wait >= TMO) begin m_to = 1; m_ph = PH_DEAD; end
`endif
          end
        end
        PH_HOLD: begin
          if (!Stall) begin
            tgt = PCSrc ? m_pc + ImmExt : m_pc + 32'd4;
            m_valid = 0;
            if (tgt % 4 != 0) begin
              m_mis = 1; m_ph = PH_DEAD;
            end else begin
              m_pc = tgt; m_ph = PH_FETCH; m_wait = 0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("cyc_req",     IMemReq,      32'(m_ph == PH_FETCH));
      chk("cyc_addr",    IMemAddr,     m_pc);
      chk("cyc_pc",      PC,           m_pc);
      chk("cyc_pcplus4", PCPlus4,      m_pc + 32'd4);
      chk("cyc_instr",   Instr,        m_instr);
      chk("cyc_valid",   InstrValid,   32'(m_valid));
      chk("cyc_mis",     MisalignErr,  32'(m_mis));
      chk("cyc_tmo",     FetchTimeout, 32'(m_to));
    end
  end

  task automatic drive();
    logic [31:0] r;
    IMemAck   = ($urandom_range(0, 99) < ack_pct);
    IMemRData = IMemAck ? mem_word(IMemAddr) : $urandom();
    Stall     = ($urandom_range(0, 99) < stall_pct);
    PCSrc     = ($urandom_range(0, 99) < br_pct);
    r         = $urandom();
    ImmExt    = {{20{r[11]}}, r[11:0]};
    if ($urandom_range(0, 99) >= mis_pct) ImmExt[1:0] = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; drive();
    @(negedge clk); rst = 1'b0; drive();
  endtask

  // Returns at a negedge with the DUT in EXEC at the given PC; inputs for the
  // coming edge are left to the caller.
  task automatic run_to_exec(input logic [31:0] pc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (InstrValid === 1'b1 && PC === pc) begin ok = 1'b1; break; end
      drive();
    end
    chk({nm, "_reach"}, 32'(ok), 32'd1);
  endtask

  initial begin
    rst = 1'b1; PCSrc = 1'b0; Stall = 1'b0; ImmExt = '0; IMemAck = 1'b0; IMemRData = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_pc",    PC,           RESET_PC);
    chk("rst_addr",  IMemAddr,     RESET_PC);
    chk("rst_req",   IMemReq,      32'd0);
    chk("rst_valid", InstrValid,   32'd0);
    chk("rst_instr", Instr,        32'h0000_0013);
    chk("rst_mis",   MisalignErr,  32'd0);
    chk("rst_tmo",   FetchTimeout, 32'd0);
    rst = 1'b0; drive();

    // Zero-wait sequential fetch: REQ/EXEC alternating at 0,4,8,C
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_req",   IMemReq,    32'(i % 2 == 0));
      chk("t1_valid", InstrValid, 32'(i % 2 == 1));
      chk("t1_addr",  IMemAddr,   32'(4 * (i / 2)));
      if (i % 2 == 1) chk("t1_instr", Instr, mem_word(32'(4 * (i / 2))));
      drive();
    end

    // Backward branch from 0x10 by -8
    run_to_exec(32'h10, "t2");
    PCSrc = 1'b1; ImmExt = 32'hFFFF_FFF8; Stall = 1'b0; IMemAck = 1'b0;
    @(negedge clk);
    chk("t2_req",  IMemReq,  32'd1);
    chk("t2_addr", IMemAddr, 32'h8);
    drive();

    // Stall holds for three edges, retires on the fourth
    @(negedge clk);
    chk("t3_valid0", InstrValid, 32'd1);
    chk("t3_pc0",    PC,         32'h8);
    for (int k = 0; k < 3; k++) begin
      Stall = 1'b1; PCSrc = 1'b1; ImmExt = 32'h40; IMemAck = 1'b1; IMemRData = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t3_instr", Instr,      mem_word(32'h8));
      chk("t3_pc",    PC,         32'h8);
      chk("t3_req",   IMemReq,    32'd0);
      chk("t3_valid", InstrValid, 32'd1);
    end
    Stall = 1'b0; PCSrc = 1'b0; IMemAck = 1'b0;
    @(negedge clk);
    chk("t3_ret_req",   IMemReq,    32'd1);
    chk("t3_ret_addr",  IMemAddr,   32'hC);
    chk("t3_ret_valid", InstrValid, 32'd0);
    drive();

    // Misaligned taken target halts until reset
    run_to_exec(32'h20, "t4");
    PCSrc = 1'b1; ImmExt = 32'd6; Stall = 1'b0; IMemAck = 1'b1;
    br_pct = 50;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_mis",   MisalignErr, 32'd1);
      chk("t4_req",   IMemReq,     32'd0);
      chk("t4_valid", InstrValid,  32'd0);
      chk("t4_pc",    PC,          32'h20);
      drive();
    end
    br_pct = 0;

    // Target arithmetic wraps modulo 2^32
    do_reset();
    run_to_exec(32'h0, "tw");
    PCSrc = 1'b1; ImmExt = 32'hFFFF_FFFC; Stall = 1'b0; IMemAck = 1'b0;
    @(negedge clk);
    chk("tw_addr0", IMemAddr, 32'hFFFF_FFFC);
    chk("tw_p4",    PCPlus4,  32'h0);
    drive();
    run_to_exec(32'hFFFF_FFFC, "tw2");
    PCSrc = 1'b1; ImmExt = 32'd8; Stall = 1'b0; IMemAck = 1'b0;
    @(negedge clk);
    chk("tw_addr1", IMemAddr, 32'h4);
    drive();

    // Reset during REQ; late ack lands in IDLE and is ignored
    do_reset();
    ack_pct = 0;
    repeat (3) begin @(negedge clk); drive(); end
    @(negedge clk);
    chk("t5_inreq", IMemReq, 32'd1);
    drive(); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; IMemAck = 1'b1; IMemRData = 32'h1234_5678;
    chk("t5_req_drop", IMemReq, 32'd0);
    chk("t5_pc",       PC,      RESET_PC);
    @(negedge clk);
    chk("t5_restart", IMemReq,    32'd1);
    chk("t5_valid",   InstrValid, 32'd0);
    chk("t5_instr",   Instr,      32'h0000_0013);
    ack_pct = 100; drive();

    // No ack for 20 REQ cycles
    do_reset();
    ack_pct = 0;
    repeat (20) begin @(negedge clk); drive(); end
    @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    chk("t6_tmo", FetchTimeout, 32'd1);
    chk("t6_req", IMemReq,      32'd0);
`else
    chk("t6_tmo", FetchTimeout, 32'd0);
    chk("t6_req", IMemReq,      32'd1);
`endif
    drive();

    // Randomized traffic with occasional resets
    do_reset();
    ack_pct = 60; stall_pct = 30; br_pct = 30; mis_pct = 4;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (m_ph == PH_DEAD && $urandom_range(0, 7) == 0) rst = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      else rst = 1'b0;
      drive();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
